// File: rtl/ex_mem_flag_stage_if.sv
// ============================================================================
// Module  : ex_mem_flag_stage_if
// Brief   : EX->MEM boundary bundle: EX-side inputs, stall/flush control,
//           latched MEM outputs and the NZCV/branch flag views.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_flag_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_result;
  logic                      ex_carryout;
  logic                      ex_overflow;
  logic                      ex_set_flags;
  logic                      ex_reg_write;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      stall;
  logic                      flush;

  logic                      mem_valid;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_reg_write;
  logic [3:0]                flags;
  logic [3:0]                br_flags;
  logic                      ex_zero;

  // Upstream EX stage / hazard unit side
  modport master (
    output ex_valid, ex_result, ex_carryout, ex_overflow, ex_set_flags,
           ex_reg_write, ex_rd, stall, flush,
    input  mem_valid, mem_result, mem_rd, mem_reg_write, flags, br_flags,
           ex_zero
  );

  // Pipeline register side
  modport slave (
    input  ex_valid, ex_result, ex_carryout, ex_overflow, ex_set_flags,
           ex_reg_write, ex_rd, stall, flush,
    output mem_valid, mem_result, mem_rd, mem_reg_write, flags, br_flags,
           ex_zero
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_flag_stage.sv
// ============================================================================
// Module  : ex_mem_flag_stage
// Brief   : EX/MEM pipeline latch with architectural NZCV register, zero
//           detect and branch flag view. Optional macro FLAG_FWD_EN forwards
//           the EX-stage NZCV to br_flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_flag_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  wire                        clk,
  input  wire                        rst_n,
  ex_mem_flag_stage_if.slave         bus
);

  logic                      mem_valid_q;
  logic [DATA_WIDTH-1:0]     mem_result_q;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
  logic                      mem_reg_write_q;
  logic [3:0]                flags_q;
  logic [3:0]                ex_nzcv;
  logic                      ex_writes_flags;

  always_comb begin
    ex_nzcv = {bus.ex_result[DATA_WIDTH-1], ~|bus.ex_result,
               bus.ex_carryout, bus.ex_overflow};
    ex_writes_flags = bus.ex_valid & bus.ex_set_flags;
  end

  // Priority: reset > flush > stall > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q     <= 1'b0;
      mem_result_q    <= '0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      flags_q         <= 4'b0000;
    end else if (bus.flush) begin
      mem_valid_q     <= 1'b0;
      mem_result_q    <= '0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
    end else if (!bus.stall) begin
      mem_valid_q     <= bus.ex_valid;
      mem_result_q    <= bus.ex_result;
      mem_rd_q        <= bus.ex_rd;
      mem_reg_write_q <= bus.ex_valid & bus.ex_reg_write;
      if (ex_writes_flags) begin
        flags_q <= ex_nzcv;
      end
    end
  end

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_result    = mem_result_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_reg_write = mem_reg_write_q;
  assign bus.flags         = flags_q;
  assign bus.ex_zero       = ~|bus.ex_result;

`ifdef FLAG_FWD_EN
  // A stalled flag-setter is still in EX, so forwarding stays active under stall
  assign bus.br_flags = (ex_writes_flags & ~bus.flush) ? ex_nzcv : flags_q;
`else
  assign bus.br_flags = flags_q;
`endif

endmodule

`default_nettype wire
